// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: front-end for an external iterative divider.
// Accepts one request at a time and normalises word-op operands.
// A one-entry result cache short-circuits repeated identical divisions.
// The result is held on the writeback port until it is consumed.
module div_issue_ctrl #(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    // upstream request
    input  logic                     fu_valid_i,
    output logic                     fu_ready_o,
    input  logic [2:0]               operation_i,
    input  logic [WIDTH-1:0]         operand_a_i,
    input  logic [WIDTH-1:0]         operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic                     flush_i,
    // divider request side
    output logic                     div_vld_o,
    input  logic                     div_rdy_i,
    output logic [WIDTH-1:0]         div_op_a_o,
    output logic [WIDTH-1:0]         div_op_b_o,
    output logic [1:0]               div_opcode_o,
    output logic [TRANS_ID_BITS-1:0] div_id_o,
    // divider response side
    input  logic                     div_out_vld_i,
    output logic                     div_out_rdy_o,
    input  logic [WIDTH-1:0]         div_res_i,
    input  logic [TRANS_ID_BITS-1:0] div_id_i,
    // writeback
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [WIDTH-1:0]         result_o,
    output logic [TRANS_ID_BITS-1:0] result_id_o
);

    localparam int unsigned EXT = WIDTH - 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t                   r_state;
    logic                     r_fu_ready;
    logic                     r_div_vld;
    logic                     r_div_out_rdy;
    logic                     r_res_valid;
    logic [WIDTH-1:0]         r_op_a;
    logic [WIDTH-1:0]         r_op_b;
    logic [2:0]               r_oper;
    logic [TRANS_ID_BITS-1:0] r_id;
    logic [WIDTH-1:0]         r_result;
    logic [TRANS_ID_BITS-1:0] r_result_id;

    // one-entry result cache
    logic                     r_c_valid;
    logic [WIDTH-1:0]         r_c_a;
    logic [WIDTH-1:0]         r_c_b;
    logic [2:0]               r_c_op;
    logic [WIDTH-1:0]         r_c_res;

    logic [WIDTH-1:0]         w_ext_a;
    logic [WIDTH-1:0]         w_ext_b;
    logic [WIDTH-1:0]         w_res_ext;
    logic                     w_accept;
    logic                     w_hit;
    logic                     w_resp_ok;

    // Operand normalisation, cache lookup and response qualification.
    always_comb begin
        w_ext_a = operand_a_i;
        w_ext_b = operand_b_i;
        if (operation_i[2]) begin
            if (operation_i[0]) begin
                w_ext_a = {{EXT{operand_a_i[31]}}, operand_a_i[31:0]};
                w_ext_b = {{EXT{operand_b_i[31]}}, operand_b_i[31:0]};
            end else begin
                w_ext_a = {{EXT{1'b0}}, operand_a_i[31:0]};
                w_ext_b = {{EXT{1'b0}}, operand_b_i[31:0]};
            end
        end
        w_res_ext = r_oper[2] ? {{EXT{div_res_i[31]}}, div_res_i[31:0]} : div_res_i;
        // flush has priority over acceptance
        w_accept  = fu_valid_i & r_fu_ready & (r_state == IDLE) & ~flush_i;
        w_hit     = r_c_valid & (r_c_a == w_ext_a) & (r_c_b == w_ext_b)
                  & (r_c_op == operation_i);
        w_resp_ok = div_out_vld_i & r_div_out_rdy & (div_id_i == r_id);
    end

    // Control FSM with registered handshake outputs and result cache.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_fu_ready    <= 1'b0;
            r_div_vld     <= 1'b0;
            r_div_out_rdy <= 1'b0;
            r_res_valid   <= 1'b0;
            r_result      <= '0;
            r_result_id   <= '0;
            r_c_valid     <= 1'b0;
        end else if (flush_i) begin
            // abandon everything; a response in this cycle is not cached
            r_state       <= IDLE;
            r_fu_ready    <= 1'b1;
            r_div_vld     <= 1'b0;
            r_div_out_rdy <= 1'b0;
            r_res_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a     <= w_ext_a;
                        r_op_b     <= w_ext_b;
                        r_oper     <= operation_i;
                        r_id       <= trans_id_i;
                        r_fu_ready <= 1'b0;
                        if (w_hit) begin
                            r_result    <= r_c_res;
                            r_result_id <= trans_id_i;
                            r_res_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_div_vld <= 1'b1;
                            r_state   <= ISSUE;
                        end
                    end else begin
                        r_fu_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (div_rdy_i) begin
                        r_div_vld     <= 1'b0;
                        r_div_out_rdy <= 1'b1;
                        r_state       <= WAIT;
                    end
                end
                WAIT: begin
                    // responses tagged with a stale ID are silently dropped
                    if (w_resp_ok) begin
                        r_result      <= w_res_ext;
                        r_result_id   <= r_id;
                        r_res_valid   <= 1'b1;
                        r_div_out_rdy <= 1'b0;
                        r_c_valid     <= 1'b1;
                        r_c_a         <= r_op_a;
                        r_c_b         <= r_op_b;
                        r_c_op        <= r_oper;
                        r_c_res       <= w_res_ext;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (result_ready_i) begin
                        r_res_valid <= 1'b0;
                        r_fu_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fu_ready_o     = r_fu_ready;
    assign div_vld_o      = r_div_vld & ~flush_i;
    assign div_op_a_o     = r_op_a;
    assign div_op_b_o     = r_op_b;
    assign div_opcode_o   = r_oper[1:0];
    assign div_id_o       = r_id;
    assign div_out_rdy_o  = r_div_out_rdy;
    assign result_valid_o = r_res_valid & ~flush_i;
    assign result_o       = r_result;
    assign result_id_o    = r_result_id;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed and randomized transactions against a
// transaction-level model of the issue controller and its result cache.
// The bench plays the role of the external divider.
module tb_div_issue_ctrl;

    localparam int unsigned W  = 64;
    localparam int unsigned IB = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          fu_valid_i;
    logic          fu_ready_o;
    logic [2:0]    operation_i;
    logic [W-1:0]  operand_a_i;
    logic [W-1:0]  operand_b_i;
    logic [IB-1:0] trans_id_i;
    logic          flush_i;
    logic          div_vld_o;
    logic          div_rdy_i;
    logic [W-1:0]  div_op_a_o;
    logic [W-1:0]  div_op_b_o;
    logic [1:0]    div_opcode_o;
    logic [IB-1:0] div_id_o;
    logic          div_out_vld_i;
    logic          div_out_rdy_o;
    logic [W-1:0]  div_res_i;
    logic [IB-1:0] div_id_i;
    logic          result_valid_o;
    logic          result_ready_i;
    logic [W-1:0]  result_o;
    logic [IB-1:0] result_id_o;

    always #5 clk_i = ~clk_i;

    div_issue_ctrl #(.WIDTH(W), .TRANS_ID_BITS(IB)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .fu_valid_i     (fu_valid_i),
        .fu_ready_o     (fu_ready_o),
        .operation_i    (operation_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .trans_id_i     (trans_id_i),
        .flush_i        (flush_i),
        .div_vld_o      (div_vld_o),
        .div_rdy_i      (div_rdy_i),
        .div_op_a_o     (div_op_a_o),
        .div_op_b_o     (div_op_b_o),
        .div_opcode_o   (div_opcode_o),
        .div_id_o       (div_id_o),
        .div_out_vld_i  (div_out_vld_i),
        .div_out_rdy_o  (div_out_rdy_o),
        .div_res_i      (div_res_i),
        .div_id_i       (div_id_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .result_id_o    (result_id_o)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // reference model of the cache: last completed division
    bit           m_valid = 1'b0;
    logic [63:0]  m_a, m_b, m_res;
    logic [2:0]   m_op;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] sext32(input logic [63:0] v);
        logic signed [31:0] lo;
        logic signed [63:0] wide;
        lo   = v[31:0];
        wide = lo;
        return wide;
    endfunction

    function automatic logic [63:0] ext_operand(input logic [63:0] v, input logic [2:0] op);
        logic [63:0] r;
        if (!op[2])     r = v;
        else if (op[0]) r = sext32(v);
        else            r = {32'h0, v[31:0]};
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r;
    endfunction

    task automatic wait_ready();
        int unsigned k;
        k = 0;
        while (!fu_ready_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        chk("fu_ready_wait", 64'(fu_ready_o), 64'd1);
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic [2:0] id);
        fu_valid_i  = 1'b1;
        operation_i = op;
        operand_a_i = a;
        operand_b_i = b;
        trans_id_i  = id;
        @(negedge clk_i);
        fu_valid_i  = 1'b0;
        operand_a_i = rnd64();
        operand_b_i = rnd64();
        trans_id_i  = 3'($urandom());
    endtask

    // One full request: issue (or cache hit), response, writeback hold, handshake.
    task automatic run_txn(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] id, input logic [63:0] res,
                           input int unsigned rdy_dly, input int unsigned resp_dly,
                           input int unsigned hold_dly, input bit bad_id);
        logic [63:0] ea, eb, exp_res;
        bit          hit;
        int unsigned k;
        wait_ready();
        ea  = ext_operand(a, op);
        eb  = ext_operand(b, op);
        hit = m_valid && (ea == m_a) && (eb == m_b) && (op == m_op);
        drive_req(op, a, b, id);
        if (hit) begin
            exp_res = m_res;
            chk("hit_valid", 64'(result_valid_o), 64'd1);
            chk("hit_result", result_o, exp_res);
            chk("hit_id", 64'(result_id_o), 64'(id));
            chk("hit_no_div_vld", 64'(div_vld_o), 64'd0);
        end else begin
            chk("issue_vld", 64'(div_vld_o), 64'd1);
            chk("issue_op_a", div_op_a_o, ea);
            chk("issue_op_b", div_op_b_o, eb);
            chk("issue_opcode", 64'(div_opcode_o), 64'(op[1:0]));
            chk("issue_id", 64'(div_id_o), 64'(id));
            chk("issue_fu_ready", 64'(fu_ready_o), 64'd0);
            repeat (rdy_dly) @(negedge clk_i);
            if (rdy_dly > 0) chk("issue_vld_held", 64'(div_vld_o), 64'd1);
            div_rdy_i = 1'b1;
            @(negedge clk_i);
            div_rdy_i = 1'b0;
            chk("wait_out_rdy", 64'(div_out_rdy_o), 64'd1);
            chk("wait_vld_low", 64'(div_vld_o), 64'd0);
            if (bad_id) begin
                div_out_vld_i = 1'b1;
                div_id_i      = id ^ 3'd1;
                div_res_i     = rnd64();
                @(negedge clk_i);
                div_out_vld_i = 1'b0;
                chk("bad_id_dropped", 64'(result_valid_o), 64'd0);
                chk("bad_id_still_rdy", 64'(div_out_rdy_o), 64'd1);
            end
            repeat (resp_dly) @(negedge clk_i);
            div_out_vld_i = 1'b1;
            div_id_i      = id;
            div_res_i     = res;
            #1;
            chk("resp_not_same_cycle", 64'(result_valid_o), 64'd0);
            @(negedge clk_i);
            div_out_vld_i = 1'b0;
            div_res_i     = rnd64();
            k = 0;
            while (!result_valid_o && k < 8) begin
                @(negedge clk_i);
                k++;
            end
            exp_res = op[2] ? sext32(res) : res;
            chk("miss_valid", 64'(result_valid_o), 64'd1);
            chk("miss_result", result_o, exp_res);
            chk("miss_id", 64'(result_id_o), 64'(id));
            m_valid = 1'b1;
            m_a     = ea;
            m_b     = eb;
            m_op    = op;
            m_res   = exp_res;
        end
        for (int i = 0; i < int'(hold_dly); i++) begin
            result_ready_i = 1'b0;
            @(negedge clk_i);
            chk("hold_valid", 64'(result_valid_o), 64'd1);
            chk("hold_result", result_o, exp_res);
            chk("hold_id", 64'(result_id_o), 64'(id));
            chk("hold_fu_ready", 64'(fu_ready_o), 64'd0);
            chk("hold_div_vld", 64'(div_vld_o), 64'd0);
        end
        chk("hs_cycle_fu_ready", 64'(fu_ready_o), 64'd0);
        result_ready_i = 1'b1;
        @(negedge clk_i);
        result_ready_i = 1'b0;
        chk("after_hs_valid", 64'(result_valid_o), 64'd0);
        chk("after_hs_fu_ready", 64'(fu_ready_o), 64'd1);
    endtask

    // Reach the WAIT state with a fresh miss, leaving the response undriven.
    task automatic issue_to_wait(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] id);
        wait_ready();
        drive_req(op, a, b, id);
        chk("pre_issue_vld", 64'(div_vld_o), 64'd1);
        div_rdy_i = 1'b1;
        @(negedge clk_i);
        div_rdy_i = 1'b0;
        chk("pre_wait_out_rdy", 64'(div_out_rdy_o), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pool [6];
        logic [2:0]  l_op;
        logic [63:0] l_a, l_b;
        pool[0] = 64'd100;
        pool[1] = 64'd7;
        pool[2] = 64'hFFFF_FFFF_8000_0000;
        pool[3] = 64'h1_0000_0005;
        pool[4] = 64'd3;
        pool[5] = 64'hFFFF_FFFF;

        rst_ni = 1'b0; fu_valid_i = 1'b0; operation_i = '0; operand_a_i = '0;
        operand_b_i = '0; trans_id_i = '0; flush_i = 1'b0; div_rdy_i = 1'b0;
        div_out_vld_i = 1'b0; div_res_i = '0; div_id_i = '0; result_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // reset state
        chk("rst_fu_ready", 64'(fu_ready_o), 64'd0);
        chk("rst_div_vld", 64'(div_vld_o), 64'd0);
        chk("rst_out_rdy", 64'(div_out_rdy_o), 64'd0);
        chk("rst_res_valid", 64'(result_valid_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_result_id", 64'(result_id_o), 64'd0);
        rst_ni = 1'b1;

        // DIV 100/7, ID 2, divider returns 14
        run_txn(3'b001, 64'd100, 64'd7, 3'd2, 64'd14, 0, 0, 1, 1'b0);
        // DIVW with sign-extended operands and sign-extended result
        run_txn(3'b101, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF, 3'd3,
                64'h0000_0000_8000_0000, 2, 1, 1, 1'b0);
        // REMUW: upper operand bits discarded
        run_txn(3'b110, 64'h1_0000_0005, 64'd3, 3'd6, 64'd2, 0, 0, 1, 1'b1);
        // DIVU 50/5 twice back-to-back; second is a cache hit, held 5 cycles
        run_txn(3'b000, 64'd50, 64'd5, 3'd4, 64'd10, 1, 2, 1, 1'b0);
        run_txn(3'b000, 64'd50, 64'd5, 3'd4, 64'd99, 0, 0, 5, 1'b0);

        // flush in WAIT with a response in the same cycle: nothing cached
        issue_to_wait(3'b001, 64'd81, 64'd9, 3'd5);
        flush_i = 1'b1; div_out_vld_i = 1'b1; div_id_i = 3'd5; div_res_i = 64'd9;
        #1;
        chk("flush_cycle_res_valid", 64'(result_valid_o), 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0; div_out_vld_i = 1'b0;
        chk("post_flush_res_valid", 64'(result_valid_o), 64'd0);
        chk("post_flush_fu_ready", 64'(fu_ready_o), 64'd1);
        chk("post_flush_out_rdy", 64'(div_out_rdy_o), 64'd0);
        run_txn(3'b001, 64'd81, 64'd9, 3'd5, 64'd9, 0, 0, 1, 1'b0);

        // flush in ISSUE masks div_vld_o in the flush cycle
        wait_ready();
        drive_req(3'b011, 64'd1000, 64'd33, 3'd1);
        chk("issue_before_flush", 64'(div_vld_o), 64'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_cycle_div_vld", 64'(div_vld_o), 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("issue_flush_fu_ready", 64'(fu_ready_o), 64'd1);
        chk("issue_flush_div_vld", 64'(div_vld_o), 64'd0);

        // flush beats a request in IDLE
        fu_valid_i = 1'b1; operation_i = 3'b001; operand_a_i = 64'd7; operand_b_i = 64'd2;
        trans_id_i = 3'd7; flush_i = 1'b1;
        @(negedge clk_i);
        fu_valid_i = 1'b0; flush_i = 1'b0;
        chk("idle_flush_no_issue", 64'(div_vld_o), 64'd0);
        chk("idle_flush_no_result", 64'(result_valid_o), 64'd0);
        chk("idle_flush_fu_ready", 64'(fu_ready_o), 64'd1);

        // cache survives flush: 81/9 still hits
        run_txn(3'b001, 64'd81, 64'd9, 3'd2, 64'd0, 0, 0, 1, 1'b0);

        // reset mid-operation abandons it and invalidates the cache
        run_txn(3'b000, 64'd50, 64'd5, 3'd4, 64'd10, 0, 0, 1, 1'b0);
        issue_to_wait(3'b001, 64'd77, 64'd7, 3'd6);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midrst_fu_ready", 64'(fu_ready_o), 64'd0);
        chk("midrst_out_rdy", 64'(div_out_rdy_o), 64'd0);
        chk("midrst_res_valid", 64'(result_valid_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_result_id", 64'(result_id_o), 64'd0);
        rst_ni  = 1'b1;
        m_valid = 1'b0;
        run_txn(3'b000, 64'd50, 64'd5, 3'd4, 64'd10, 0, 0, 1, 1'b0);

        // randomized traffic with repeats to exercise hits
        l_op = 3'b001; l_a = 64'd100; l_b = 64'd7;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                l_op = 3'($urandom());
                l_a  = ($urandom_range(0, 3) == 0) ? rnd64() : pool[$urandom_range(0, 5)];
                l_b  = ($urandom_range(0, 3) == 0) ? rnd64() : pool[$urandom_range(0, 5)];
            end
            run_txn(l_op, l_a, l_b, 3'($urandom()), rnd64(),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
